// File: rtl/audio_nios_key_pkg.sv
// Shared types and helpers for the DE1-SoC push-button debouncer.
package audio_nios_key_pkg;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    PEND_DN = 2'd1,
    DOWN    = 2'd2,
    PEND_UP = 2'd3
  } key_state_t;

  localparam logic KEY_RELEASED = 1'b1;

  // Smallest counter width w with 2^w > cycles.
  function automatic int min_cnt_w(input int cycles);
    int w;
    w = 1;
    while ((longint'(1) << w) <= longint'(cycles)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/audio_nios_key_debounce_if.sv
// Key bundle between the raw pins, the debouncer and its consumers (PIO, audio control).
interface audio_nios_key_debounce_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_clean;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_repeat;

  modport master (
    output key_raw,
    input  key_clean, key_press, key_release, key_repeat
  );

  modport slave (
    input  key_raw,
    output key_clean, key_press, key_release, key_repeat
  );
endinterface

// File: rtl/audio_nios_key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM and counter.
// Auto-repeat is built only when AUDIO_NIOS_KEY_DEBOUNCE_REPEAT_EN is defined.
module audio_nios_key_debounce_chan
  import audio_nios_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_level,
  output logic clean_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  key_state_t       state;
  logic [CNT_W-1:0] cnt;

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("audio_nios_key_debounce_chan: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  // A new level must be seen on s2 for DEBOUNCE_CYCLES consecutive PEND cycles before acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1            <= KEY_RELEASED;
      s2            <= KEY_RELEASED;
      state         <= UP;
      cnt           <= '0;
      clean_level   <= KEY_RELEASED;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= raw_level;
      s2            <= s1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        UP: begin
          if (s2 != KEY_RELEASED) begin
            state <= PEND_DN;
            cnt   <= '0;
          end
        end
        PEND_DN: begin
          if (s2 == KEY_RELEASED) begin
            state <= UP;
            cnt   <= '0;
          end else if (cnt == LIMIT) begin
            state       <= DOWN;
            clean_level <= ~KEY_RELEASED;
            press_pulse <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DOWN: begin
          if (s2 == KEY_RELEASED) begin
            state <= PEND_UP;
            cnt   <= '0;
          end
        end
        PEND_UP: begin
          if (s2 != KEY_RELEASED) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == LIMIT) begin
            state         <= UP;
            clean_level   <= KEY_RELEASED;
            release_pulse <= 1'b1;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= UP;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef AUDIO_NIOS_KEY_DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_periodic;

  // Counts only while held in DOWN; the first interval is REPEAT_DELAY, later ones REPEAT_PERIOD.
  always_ff @(posedge clk) begin
    if (reset || state != DOWN || s2 == KEY_RELEASED) begin
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b0;
      repeat_pulse <= 1'b0;
    end else if (!rpt_periodic && rpt_cnt == RPT_W'(REPEAT_DELAY - 1)) begin
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b1;
      repeat_pulse <= 1'b1;
    end else if (rpt_periodic && rpt_cnt == RPT_W'(REPEAT_PERIOD - 1)) begin
      rpt_cnt      <= '0;
      repeat_pulse <= 1'b1;
    end else begin
      rpt_cnt      <= rpt_cnt + 1'b1;
      repeat_pulse <= 1'b0;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/audio_nios_key_debounce.sv
// Debounces NUM_KEYS push buttons in front of the key PIO and emits press/release strobes.
// Optional auto-repeat strobes: define AUDIO_NIOS_KEY_DEBOUNCE_REPEAT_EN.
module audio_nios_key_debounce
  import audio_nios_key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                       clk,
  input  logic                       reset,
  audio_nios_key_debounce_if.slave   keys
);

  logic [NUM_KEYS-1:0] clean_bus;
  logic [NUM_KEYS-1:0] press_bus;
  logic [NUM_KEYS-1:0] release_bus;
  logic [NUM_KEYS-1:0] repeat_bus;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 16777215 ||
      CNT_W < min_cnt_w(DEBOUNCE_CYCLES)) begin : g_bad_cnt
    $error("audio_nios_key_debounce: DEBOUNCE_CYCLES out of range or CNT_W too narrow");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    audio_nios_key_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .raw_level     (keys.key_raw[i]),
      .clean_level   (clean_bus[i]),
      .press_pulse   (press_bus[i]),
      .release_pulse (release_bus[i]),
      .repeat_pulse  (repeat_bus[i])
    );
  end

  assign keys.key_clean   = clean_bus;
  assign keys.key_press   = press_bus;
  assign keys.key_release = release_bus;
  assign keys.key_repeat  = repeat_bus;

endmodule

// File: tb/tb_audio_nios_key_debounce.sv
// Self-checking bench for audio_nios_key_debounce against a run-length reference model.
module tb_audio_nios_key_debounce;

  localparam int NK     = 4;
  localparam int DEB    = 8;
  localparam int RDELAY = 20;
  localparam int RPER   = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;

  audio_nios_key_debounce_if #(.NUM_KEYS(NK)) kif ();

  audio_nios_key_debounce #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .CNT_W(4),
    .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPER)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .keys  (kif)
  );

  always #5 clk = ~clk;

  // Reference model: the raw level reaches the debouncer two samples late; a key's accepted
  // level flips once the sampled level has disagreed with it on DEB+1 consecutive clocks.
  logic [NK-1:0] dly1 = '1, dly2 = '1;
  logic [NK-1:0] m_clean = '1, m_press = '0, m_rel = '0, m_rep = '0;
  int            run [NK];
  int            held [NK];

  task automatic model_step();
    logic lvl;
    logic was_held;
    if (reset) begin
      dly1 = '1; dly2 = '1; m_clean = '1; m_press = '0; m_rel = '0; m_rep = '0;
      for (int i = 0; i < NK; i++) begin run[i] = 0; held[i] = 0; end
    end else begin
      for (int i = 0; i < NK; i++) begin
        lvl = dly2[i];
        was_held = (m_clean[i] == 1'b0) && (run[i] == 0) && (lvl == 1'b0);
        m_press[i] = 1'b0; m_rel[i] = 1'b0; m_rep[i] = 1'b0;
        if (lvl != m_clean[i]) begin
          run[i]++;
          if (run[i] == DEB + 1) begin
            m_clean[i] = lvl;
            if (lvl == 1'b0) m_press[i] = 1'b1; else m_rel[i] = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
`ifdef AUDIO_NIOS_KEY_DEBOUNCE_REPEAT_EN
        if (was_held) begin
          held[i]++;
          if (held[i] == RDELAY || (held[i] > RDELAY && (held[i] - RDELAY) % RPER == 0))
            m_rep[i] = 1'b1;
        end else begin
          held[i] = 0;
        end
`else
        held[i] = was_held ? held[i] + 1 : 0;
`endif
      end
      dly2 = dly1;
      dly1 = kif.key_raw;
    end
  endtask

  // Advance one clock: model sees the same inputs as the DUT, outputs are then read at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    kif.key_raw = '1;
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      total++;
      if ({kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat} !== {4'hF, 12'h000}) begin
        $display("[TB] FAIL reset_idle: got %h expected %h",
                 {kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat}, {4'hF, 12'h000});
      end else passed++;
    end
  endtask

  task automatic test_single_press();
    int n;
    int presses;
    n = 0; presses = 0;
    kif.key_raw[0] = 1'b0;
    while (kif.key_clean[0] !== 1'b0 && n < 40) begin
      tick(); n++;
      if (kif.key_press[0] === 1'b1) presses++;
      total++;
      if ({kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat} !== {m_clean, m_press, m_rel, m_rep}) begin
        $display("[TB] FAIL press0_model: got %h expected %h",
                 {kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat}, {m_clean, m_press, m_rel, m_rep});
      end else passed++;
    end
    // n counts the sampling edge too, so edges after it are n-1
    total++;
    if (n - 1 !== DEB + 2) $display("[TB] FAIL press0_latency: got %0d expected %0d", n - 1, DEB + 2);
    else passed++;
    total++;
    if ({kif.key_clean, kif.key_press} !== {4'hE, 4'h1}) begin
      $display("[TB] FAIL press0_strobe: got %h expected %h", {kif.key_clean, kif.key_press}, {4'hE, 4'h1});
    end else passed++;
    tick();
    if (kif.key_press[0] === 1'b1) presses++;
    total++;
    if (presses !== 1) $display("[TB] FAIL press0_count: got %0d expected 1", presses);
    else passed++;
  endtask

  task automatic test_glitch();
    int strobes;
    strobes = 0;
    for (int c = 0; c < 60; c++) begin
      if (c < 40 && c % 3 == 0) kif.key_raw[1] = ~kif.key_raw[1];
      if (c == 40) kif.key_raw[1] = 1'b1;
      tick();
      strobes += int'(kif.key_press[1]) + int'(kif.key_release[1]);
      total++;
      if ({kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat} !== {m_clean, m_press, m_rel, m_rep}) begin
        $display("[TB] FAIL glitch_model: got %h expected %h",
                 {kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat}, {m_clean, m_press, m_rel, m_rep});
      end else passed++;
    end
    total++;
    if (kif.key_clean[1] !== 1'b1 || strobes != 0)
      $display("[TB] FAIL glitch_key1: got clean=%b strobes=%0d expected clean=1 strobes=0", kif.key_clean[1], strobes);
    else passed++;
  endtask

  task automatic test_simultaneous();
    int press_seen;
    int rel_at;
    press_seen = 0; rel_at = -1;
    kif.key_raw[3:2] = 2'b00;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (kif.key_press == 4'hC) press_seen++;
      total++;
      if ({kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat} !== {m_clean, m_press, m_rel, m_rep}) begin
        $display("[TB] FAIL simul_model: got %h expected %h",
                 {kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat}, {m_clean, m_press, m_rel, m_rep});
      end else passed++;
    end
    kif.key_raw[3:2] = 2'b11;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (kif.key_release == 4'hC && rel_at < 0) rel_at = c;
      total++;
      if ({kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat} !== {m_clean, m_press, m_rel, m_rep}) begin
        $display("[TB] FAIL simul_model: got %h expected %h",
                 {kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat}, {m_clean, m_press, m_rel, m_rep});
      end else passed++;
    end
    total++;
    if (press_seen !== 1) $display("[TB] FAIL simul_press: got %0d cycles of 4'hC expected 1", press_seen);
    else passed++;
    total++;
    if (rel_at !== DEB + 2) $display("[TB] FAIL simul_release_latency: got %0d expected %0d", rel_at, DEB + 2);
    else passed++;
  endtask

  task automatic test_reset_mid_debounce();
    int n;
    int releases;
    n = 0; releases = 0;
    kif.key_raw[0] = 1'b1;
    for (int c = 0; c < 15; c++) tick();
    kif.key_raw[0] = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat} !== {4'hF, 12'h000}) begin
      $display("[TB] FAIL rst_mid_state: got %h expected %h",
               {kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat}, {4'hF, 12'h000});
    end else passed++;
    while (kif.key_clean[0] !== 1'b0 && n < 40) begin
      tick(); n++;
      releases += int'(kif.key_release[0]);
      total++;
      if ({kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat} !== {m_clean, m_press, m_rel, m_rep}) begin
        $display("[TB] FAIL rst_mid_model: got %h expected %h",
                 {kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat}, {m_clean, m_press, m_rel, m_rep});
      end else passed++;
    end
    total++;
    if (n - 1 !== DEB + 2 || releases != 0)
      $display("[TB] FAIL rst_mid_redebounce: got latency=%0d releases=%0d expected %0d/0", n - 1, releases, DEB + 2);
    else passed++;
    kif.key_raw[0] = 1'b1;
    for (int c = 0; c < 15; c++) tick();
  endtask

  task automatic test_repeat();
    int offs [$];
    int exp_offs [$];
    int n;
    n = 0;
    kif.key_raw[3] = 1'b0;
    while (kif.key_press[3] !== 1'b1 && n < 40) begin tick(); n++; end
    total++;
    if (kif.key_press[3] !== 1'b1) $display("[TB] FAIL repeat_press: got 0 expected 1");
    else passed++;
    for (int c = 1; c <= 80; c++) begin
      if (c == 51) kif.key_raw[3] = 1'b1;
      tick();
      if (kif.key_repeat[3] === 1'b1) offs.push_back(c);
      total++;
      if ({kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat} !== {m_clean, m_press, m_rel, m_rep}) begin
        $display("[TB] FAIL repeat_model: got %h expected %h",
                 {kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat}, {m_clean, m_press, m_rel, m_rep});
      end else passed++;
    end
`ifdef AUDIO_NIOS_KEY_DEBOUNCE_REPEAT_EN
    for (int k = RDELAY; k <= 50; k += RPER) exp_offs.push_back(k);
`endif
    total++;
    if (offs.size() != exp_offs.size())
      $display("[TB] FAIL repeat_count: got %0d expected %0d", offs.size(), exp_offs.size());
    else passed++;
    for (int i = 0; i < offs.size() && i < exp_offs.size(); i++) begin
      total++;
      if (offs[i] != exp_offs[i]) $display("[TB] FAIL repeat_offset%0d: got %0d expected %0d", i, offs[i], exp_offs[i]);
      else passed++;
    end
    for (int c = 0; c < 15; c++) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(11) == 0) kif.key_raw[i] = ~kif.key_raw[i];
      reset = ($urandom_range(199) == 0);
      tick();
      total++;
      if ({kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat} !== {m_clean, m_press, m_rel, m_rep}) begin
        $display("[TB] FAIL random_model: cycle %0d got %h expected %h", c,
                 {kif.key_clean, kif.key_press, kif.key_release, kif.key_repeat}, {m_clean, m_press, m_rel, m_rep});
      end else passed++;
    end
    reset = 1'b0;
  endtask

  initial begin
    kif.key_raw = '1;
    for (int i = 0; i < NK; i++) begin run[i] = 0; held[i] = 0; end
    @(negedge clk);
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_reset_mid_debounce();
    test_repeat();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
